// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage constants, vectors and interrupt FSM states
package mips_pkg;

  // Encoding written into IF/ID when a slot is squashed
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Default reset and entry vectors; if_stage parameters fall back to these
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h8000_0008;

  // Interrupt request tracking: nothing outstanding, or an edge waiting for entry
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } irq_state_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with clear over hold over load
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        hold,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // Squash beats hold; hold beats a fresh load
  always_comb begin
    inst_d     = inst_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (clear) begin
      inst_d     = NOP_INST;
      pc_plus4_d = 32'h0;
      valid_d    = 1'b0;
    end else if (!hold) begin
      inst_d     = inst_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  // Register update; reset leaves an empty bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q     <= NOP_INST;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      inst_q     <= inst_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign inst     = inst_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - fetch stage: PC, next-PC selection, IF/ID, interrupt entry (IF_STAGE_IRQ_EN)
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] IRQ_VEC  = DEF_IRQ_VEC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        if_id_clear,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exc_req,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] epc,
  output logic        irq_ack
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        irq_ack_q, irq_ack_d;
  logic        irq_take;
  logic        if_id_flush;
  logic [31:0] pc_plus4;
  logic [31:0] jump_dest, branch_dest;

  assign pc_plus4 = pc_q + 32'd4;

  // A redirect may only stay in kernel space if it started there
  assign jump_dest   = {pc_q[31] & jump_target[31],   jump_target[30:0]};
  assign branch_dest = {pc_q[31] & branch_target[31], branch_target[30:0]};

`ifdef IF_STAGE_IRQ_EN
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       sync_prev_q, sync_prev_d;
  logic       irq_rise;
  irq_state_e state_q, state_d;

  // Two-flop synchroniser plus one delayed copy for rising-edge detection
  always_comb begin
    sync1_d     = irq;
    sync2_d     = sync1_q;
    sync_prev_d = sync2_q;
  end

  assign irq_rise = sync2_q & ~sync_prev_q;

  // Entry waits for user mode and a cycle with no competing PC change
  assign irq_take = (state_q == PEND) & ~pc_q[31] & ~stall & ~jump
                    & ~branch_taken & ~exc_req;

  // Edges arriving while already pending are absorbed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (irq_rise) state_d = PEND;
      PEND:    if (irq_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Synchroniser and FSM state; reset drops any pending request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_prev_q <= sync_prev_d;
      state_q     <= state_d;
    end
  end
`else
  logic irq_unused;
  assign irq_unused = irq;
  assign irq_take   = 1'b0;
`endif

  // Next PC and EPC: exception, interrupt, jump, branch, stall, sequential
  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    irq_ack_d = irq_take;
    if (exc_req) begin
      pc_d  = EXC_VEC;
      epc_d = if_id_pc_plus4 - 32'd4;
    end else if (irq_take) begin
      pc_d  = IRQ_VEC;
      epc_d = pc_q;
    end else if (jump) begin
      pc_d = jump_dest;
    end else if (branch_taken) begin
      pc_d = branch_target_sel(branch_dest);
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  function automatic logic [31:0] branch_target_sel(input logic [31:0] t);
    return t;
  endfunction

  // PC, EPC and acknowledge pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      epc_q     <= 32'h0;
      irq_ack_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  // A taken redirect also squashes the wrong-path fetch, leaving a bubble
  assign if_id_flush = if_id_clear | exc_req | irq_take | jump | branch_taken;

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .clear       (if_id_flush),
    .hold        (stall),
    .inst_in     (imem_rdata),
    .pc_plus4_in (pc_plus4),
    .inst        (if_id_inst),
    .pc_plus4    (if_id_pc_plus4),
    .valid       (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign epc       = epc_q;
  assign irq_ack   = irq_ack_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage against a behavioural fetch model
module tb_if_stage;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] IRQ_V   = 32'h8000_0004;
  localparam logic [31:0] EXC_V   = 32'h8000_0008;
`ifdef IF_STAGE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, if_id_clear, jump, branch_taken, exc_req, irq;
  logic [31:0] jump_target, branch_target;
  logic [31:0] imem_addr, imem_rdata, if_id_inst, if_id_pc_plus4, epc;
  logic        if_id_valid, irq_ack;

  always #5 clk = ~clk;

  // Instruction memory: word at address A reads as 0x1111_0000 + A
  assign imem_rdata = 32'h1111_0000 + imem_addr;

  if_stage #(.RESET_PC(RST_PC), .IRQ_VEC(IRQ_V), .EXC_VEC(EXC_V)) dut (
    .clk(clk), .reset(reset), .stall(stall), .if_id_clear(if_id_clear),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .exc_req(exc_req), .irq(irq),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_inst(if_id_inst), .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .epc(epc), .irq_ack(irq_ack)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pp4;
    logic        valid;
    logic [31:0] epc;
    logic        ack;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Architectural model state
  logic [31:0] m_pc, m_inst, m_pp4, m_epc;
  logic        m_valid, m_ack, m_pend;
  logic        irq_seen[$];  // irq level sampled at the last three edges, oldest first

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_inst = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    m_epc = 32'h0; m_ack = 1'b0; m_pend = 1'b0;
    irq_seen = {1'b0, 1'b0, 1'b0};
  endtask

  // Async reset at a falling edge, checked before any rising edge occurs
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; stall = 0; if_id_clear = 0; jump = 0; branch_taken = 0; exc_req = 0; irq = 0;
    jump_target = 0; branch_target = 0;
    #1;
    chk("rst_pc", imem_addr, RST_PC);
    chk("rst_inst", if_id_inst, 32'h0);
    chk("rst_pp4", if_id_pc_plus4, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_ack", {31'h0, irq_ack}, 32'h0);
    model_reset();
    @(posedge clk);
  endtask

  // Drive one cycle of inputs and queue what the outputs must show after the edge
  task automatic step(input logic s, input logic c, input logic j, input logic [31:0] jt,
                      input logic b, input logic [31:0] bt, input logic e, input logic i);
    logic        rise, take, flush;
    logic [31:0] npc, nepc;
    exp_t        x;
    @(negedge clk);
    reset = 1'b0; stall = s; if_id_clear = c; jump = j; jump_target = jt;
    branch_taken = b; branch_target = bt; exc_req = e; irq = i;

    rise = irq_seen[1] && !irq_seen[0];
    take = IRQ_EN && m_pend && !m_pc[31] && !s && !j && !b && !e;

    nepc = m_epc;
    if (e)         begin npc = EXC_V; nepc = m_pp4 - 32'd4; end
    else if (take) begin npc = IRQ_V; nepc = m_pc; end
    else if (j)    npc = {m_pc[31] & jt[31], jt[30:0]};
    else if (b)    npc = {m_pc[31] & bt[31], bt[30:0]};
    else if (s)    npc = m_pc;
    else           npc = m_pc + 32'd4;

    flush = c || e || take || j || b;
    if (flush) begin
      m_inst = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      m_inst = 32'h1111_0000 + m_pc; m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
    end

    m_pend = IRQ_EN && (take ? 1'b0 : (rise ? 1'b1 : m_pend));
    m_ack  = take;
    m_epc  = nepc;
    m_pc   = npc;
    void'(irq_seen.pop_front());
    irq_seen.push_back(i);

    x.pc = m_pc; x.inst = m_inst; x.pp4 = m_pp4; x.valid = m_valid;
    x.epc = m_epc; x.ack = m_ack;
    sb.push_back(x);
  endtask

  task automatic idle(input logic i);
    step(0, 0, 0, 32'h0, 0, 32'h0, 0, i);
  endtask

  task automatic jmp(input logic [31:0] t, input logic i);
    step(0, 1, 1, t, 0, 32'h0, 0, i);
  endtask

  // Monitor: compare every queued expectation just after the rising edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("pc", imem_addr, x.pc);
        chk("if_id_inst", if_id_inst, x.inst);
        chk("if_id_pc_plus4", if_id_pc_plus4, x.pp4);
        chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, x.valid});
        chk("epc", epc, x.epc);
        chk("irq_ack", {31'h0, irq_ack}, {31'h0, x.ack});
      end
    end
  end

  initial begin
    logic ri;
    reset = 1'b1; stall = 0; if_id_clear = 0; jump = 0; branch_taken = 0;
    exc_req = 0; irq = 0; jump_target = 0; branch_target = 0;
    do_reset();

    // Sequential fetch, then a two-cycle stall at 0x8000_0010
    repeat (4) idle(0);
    repeat (2) step(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    repeat (2) idle(0);

    // Drop to user code, then a jump into kernel space is forced back to user
    jmp(32'h0000_0040, 0);
    jmp(32'h8000_0100, 0);
    repeat (2) idle(0);
    step(0, 0, 0, 32'h0, 1, 32'h8000_0180, 0, 0);
    repeat (2) idle(0);

    // Interrupt entry from user code
    repeat (6) idle(1);
    repeat (3) idle(0);

    // Interrupt raised in kernel space is deferred until user code without stall
    repeat (6) idle(1);
    jmp(32'h0000_0300, 1);
    repeat (2) step(1, 0, 0, 32'h0, 0, 32'h0, 0, 1);
    repeat (3) idle(0);

    // Exception coincides with an eligible pending interrupt
    jmp(32'h0000_0400, 0);
    repeat (3) idle(0);
    repeat (4) step(1, 0, 0, 32'h0, 0, 32'h0, 0, 1);
    step(0, 0, 0, 32'h0, 0, 32'h0, 1, 1);
    repeat (2) idle(1);
    jmp(32'h0000_0500, 1);
    repeat (3) idle(0);

    // Reset while an interrupt is pending discards it
    jmp(32'h0000_0600, 0);
    repeat (4) step(1, 0, 0, 32'h0, 0, 32'h0, 0, 1);
    do_reset();
    jmp(32'h0000_0700, 0);
    repeat (5) idle(0);

    // Randomised traffic with occasional resets
    ri = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) ri = ~ri;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        ri = 1'b0;
      end else begin
        step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 11) == 0, $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 11) == 0, $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 29) == 0, ri);
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
